seg7_scan_driver: RTL and testbench

//  Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: the blank segment code,
// the active-low hex glyph table and a lookup helper.
package seg7_pkg;

  // All segments off (active-low), bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low glyphs for 0..F, entry n selected as SEG_GLYPHS[n].
  // Lower-case b and d keep them distinguishable from 8 and 0.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Nibble to active-low segment pattern.
  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    return SEG_GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup; no state.
  always_comb begin
    seg = seg7_hex(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A prescaler produces PWM ticks; each digit owns a slot of 2**PWM_BITS
// ticks whose first tick is dark dead-time against ghosting. Display inputs
// are snapshotted once per frame so a frame never shows mixed data.
// Optional build macro: LEADING_ZERO_BLANK_EN (darken digits above the most
// significant nonzero nibble; digit 0 always shows).
//
// frame_start is a strobe, not a handshake: it is high for exactly one clk
// cycle, the first cycle of every frame (index 0, PWM step 0, prescaler 0),
// and the inputs present in that cycle are the ones captured for the frame.
// There is no back-pressure; the consumer simply observes the pulse.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int PWM_BITS   = 4
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [PWM_BITS-1:0]       brightness,
  output logic [6:0]                a_to_g,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(CLK_DIV);

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] STEP_LAST = '1;
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan state.
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] step;
  logic [IDX_W-1:0]    idx;

  // Frame snapshot of the display inputs.
  logic [4*NUM_DIGITS-1:0] value_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [PWM_BITS-1:0]     bright_s;

  // Derived timing events.
  logic tick;
  logic step_wrap;
  logic frame_first;

  // Per-digit display enable after leading-zero suppression.
  logic [NUM_DIGITS-1:0] keep;

  // Selected-digit view of the snapshot.
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  sel_keep;
  logic                  lit;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_next;

  assign tick        = (pre_cnt == PRE_LAST);
  assign step_wrap   = tick && (step == STEP_LAST);
  assign frame_first = (pre_cnt == '0) && (step == '0) && (idx == '0);

  // Gated by clr so the strobe stays low while the scan is held in reset.
  assign frame_start = frame_first && !clr;

  // Prescaler: counts 0..CLK_DIV-1, tick on the terminal count.
  always_ff @(posedge clk) begin
    if (clr) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // PWM step: advances once per tick and wraps naturally at 2**PWM_BITS.
  always_ff @(posedge clk) begin
    if (clr) begin
      step <= '0;
    end else if (tick) begin
      step <= step + PWM_BITS'(1);
    end
  end

  // Digit index: advances when the PWM step wraps, NUM_DIGITS-1 -> 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx <= '0;
    end else if (step_wrap) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Snapshot: loaded in the first cycle of each frame, including the first
  // cycle after clr releases, since reset leaves the scan at that point.
  always_ff @(posedge clk) begin
    if (clr) begin
      value_s  <= '0;
      dp_s     <= '0;
      blank_s  <= '0;
      bright_s <= '0;
    end else if (frame_first) begin
      value_s  <= value;
      dp_s     <= dp_in;
      blank_s  <= blank;
      bright_s <= brightness;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is kept if it or any more significant nibble is nonzero;
  // digit 0 is always kept so a zero value still shows a single "0".
  always_comb begin
    logic any_above;
    keep      = '0;
    any_above = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_above = any_above | (|value_s[4*i +: 4]);
      keep[i]   = any_above || (i == 0);
    end
  end
`else
  // Without suppression every digit is eligible; blank_s still applies.
  always_comb begin
    keep = '1;
  end
`endif

  // Select the current digit's nibble, dp, blank and keep bits.
  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_keep  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_nib   = value_s[4*i +: 4];
        sel_dp    = dp_s[i];
        sel_blank = blank_s[i];
        sel_keep  = keep[i];
      end
    end
  end

  // Lit rule: step 0 is dead-time; steps 1..bright_s are on.
  always_comb begin
    lit = (step != '0) && (step <= bright_s) && !sel_blank && sel_keep;
  end

  // Active-low anode vector: at most one bit low, only while lit.
  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == IDX_W'(i))) begin
        an_next[i] = 1'b0;
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble (sel_nib),
    .seg    (dec_seg)
  );

  // Output registers: one clk behind the scan state, dark in reset.
  always_ff @(posedge clk) begin
    if (clr || !lit) begin
      a_to_g <= SEG_OFF;
      dp     <= 1'b1;
      an     <= '1;
    end else begin
      a_to_g <= dec_seg;
      dp     <= ~sel_dp;
      an     <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (NUM_DIGITS=4, CLK_DIV=4, PWM_BITS=2).
// The driver pushes expected outputs computed from frame position arithmetic;
// the monitor pops one entry per cycle and compares.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int P  = 2;
  localparam int S  = 1 << P;
  localparam int F  = N * S * D;
  localparam int EW = N + 7 + 1 + 1;

  // Clock / reset and DUT signals.
  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [4*N-1:0] value = '0;
  logic [N-1:0] dp_in = '0;
  logic [N-1:0] blank = '0;
  logic [P-1:0] brightness = '0;
  logic [6:0]   a_to_g;
  logic         dp;
  logic [N-1:0] an;
  logic         frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (N),
    .CLK_DIV    (D),
    .PWM_BITS   (P)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .value       (value),
    .dp_in       (dp_in),
    .blank       (blank),
    .brightness  (brightness),
    .a_to_g      (a_to_g),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  // Scoreboard: each entry is {an, a_to_g, dp, frame_start}.
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since release and the frame snapshot.
  int             pos = 0;
  logic [4*N-1:0] s_val = '0;
  logic [N-1:0]   s_dp = '0;
  logic [N-1:0]   s_blank = '0;
  logic [P-1:0]   s_bright = '0;
  logic [N+7:0]   prev_out;
  bit             prev_ok = 0;

  localparam logic [N+7:0] DARK = {{N{1'b1}}, 7'h7F, 1'b1};

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Outputs for frame position p from the current snapshot: {an, seg, dp}.
  function automatic logic [N+7:0] model_out(input int p);
    int fp;
    int dig;
    int st;
    bit lit;
    logic [N-1:0] an_v;
    fp  = p % F;
    dig = fp / (S * D);
    st  = (fp / D) % S;
    lit = (st != 0) && (st <= int'(s_bright)) && !s_blank[dig];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < N; i++) if (s_val[4*i +: 4] != 4'h0) hi = i;
      if (dig > hi) lit = 0;
    end
`endif
    if (!lit) return DARK;
    an_v = '1;
    an_v[dig] = 1'b0;
    return {an_v, glyph(s_val[4*dig +: 4]), ~s_dp[dig]};
  endfunction

  // Driver: one cycle of stimulus plus the model update for that cycle.
  task automatic drive(input logic c, input logic [4*N-1:0] v,
                       input logic [N-1:0] d, input logic [N-1:0] b,
                       input logic [P-1:0] br);
    logic fs;
    logic [N+7:0] o;
    @(negedge clk);
    clr = c; value = v; dp_in = d; blank = b; brightness = br;
    fs = !c && ((pos % F) == 0);
    if (prev_ok) exp_q.push_back({prev_out, fs});
    if (c) begin
      o = DARK;
      pos = 0; s_val = '0; s_dp = '0; s_blank = '0; s_bright = '0;
    end else begin
      o = model_out(pos);
      if ((pos % F) == 0) begin
        s_val = v; s_dp = d; s_blank = b; s_bright = br;
      end
      pos++;
    end
    prev_out = o;
    prev_ok = 1;
  endtask

  // Monitor: compare every cycle away from the active edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({an, a_to_g, dp} !== e[EW-1:1]) begin
          errors++;
          $display("FAIL outputs t=%0t an/seg/dp got %h/%b/%b want %h/%b/%b",
                   $time, an, a_to_g, dp, e[EW-1 -: N], e[8:2], e[1]);
        end
        checks++;
        if (frame_start !== e[0]) begin
          errors++;
          $display("FAIL frame_start t=%0t got %b want %b", $time, frame_start, e[0]);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [4*N-1:0] rv;
    logic [N-1:0]   rd;
    logic [N-1:0]   rb;
    logic [P-1:0]   rbr;
    int             len;

    repeat (3) drive(1, '0, '0, '0, '0);
    // Scan at full brightness, then dimmed, then off.
    repeat (2*F) drive(0, 16'h12AF, 4'h0, 4'h0, 2'd3);
    repeat (F)   drive(0, 16'h12AF, 4'h0, 4'h0, 2'd1);
    repeat (F)   drive(0, 16'h12AF, 4'h0, 4'h0, 2'd0);
    // Mid-frame change while digit 2 is lit is deferred to the next frame.
    repeat (40)     drive(0, 16'h1111, 4'h0, 4'h0, 2'd3);
    repeat (F - 40 + F) drive(0, 16'h2222, 4'h0, 4'h0, 2'd3);
    // Blank digit 2, decimal point on digit 0.
    repeat (2*F) drive(0, 16'h8421, 4'b0001, 4'b0100, 2'd3);
    // Leading-zero patterns.
    repeat (2*F) drive(0, 16'h0050, 4'h0, 4'h0, 2'd3);
    repeat (2*F) drive(0, 16'h0000, 4'h0, 4'h0, 2'd3);
    // Mid-scan reset held three cycles.
    repeat (37) drive(0, 16'hBEEF, 4'hA, 4'h0, 2'd2);
    repeat (3)  drive(1, 16'hBEEF, 4'hA, 4'h0, 2'd2);
    repeat (2*F) drive(0, 16'hC0D3, 4'h5, 4'h0, 2'd3);
    // Random traffic with occasional resets.
    for (int k = 0; k < 40; k++) begin
      rv  = 4*N'($urandom);
      rd  = N'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rbr = P'($urandom_range(0, S - 1));
      len = $urandom_range(1, F + 20);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) drive(1, rv, rd, rb, rbr);
      repeat (len) drive(0, rv, rd, rb, rbr);
    end
    // Drain the scoreboard within a bounded number of cycles.
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
